// File: rtl/fpadd_arbiter_if.sv
// Connection between the arbiter and the single fpadd unit.
// Handshake: start is a one-cycle pulse carrying a/b. done is a level that the adder
// clears on the start edge and raises when sum is valid. reset is a synchronous clear.
interface fpadd_arbiter_if;
  logic        fpa_reset;
  logic        fpa_start;
  logic [31:0] fpa_a;
  logic [31:0] fpa_b;
  logic [31:0] fpa_sum;
  logic        fpa_done;

  modport master (
    output fpa_reset, fpa_start, fpa_a, fpa_b,
    input  fpa_sum, fpa_done
  );

  modport slave (
    input  fpa_reset, fpa_start, fpa_a, fpa_b,
    output fpa_sum, fpa_done
  );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin scheduler that shares one fpadd among N_REQ requesters.
// Optional WAIT timeout is enabled by defining FPADD_ARB_TIMEOUT_EN.
module fpadd_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 64,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   a_in,
  input  logic [32*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           op_count,
  output logic [1:0]            dbg_state,
  output logic [ID_W-1:0]       dbg_ptr,
  fpadd_arbiter_if.master       fpa
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              timeout_hit;

  logic [N_REQ-1:0]  gnt_d, rsp_valid_d;
  logic [31:0]       rsp_sum_d, fpa_a_d, fpa_b_d;
  logic              rsp_err_d, busy_d, fpa_start_d, fpa_reset_d;
  logic [15:0]       op_count_d;

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state_q == ISSUE) begin
      to_cnt <= '0;
    end else if (state_q == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state_q == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && req[ID_W'(j)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (fpa.fpa_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    fpa_start_d = 1'b0;
    fpa_reset_d = 1'b0;
    rsp_sum_d   = rsp_sum;
    rsp_err_d   = rsp_err;
    fpa_a_d     = fpa.fpa_a;
    fpa_b_d     = fpa.fpa_b;
    op_count_d  = op_count;
    ptr_d       = ptr_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d[win_id] = 1'b1;
          ptr_d         = win_id;
          fpa_a_d       = a_in[{win_id, 5'd0} +: 32];
          fpa_b_d       = b_in[{win_id, 5'd0} +: 32];
          fpa_start_d   = 1'b1;
        end
      end
      // done beats a coincident timeout; done from the previous op is never seen here
      WAIT: begin
        if (fpa.fpa_done) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_sum_d          = fpa.fpa_sum;
          rsp_err_d          = 1'b0;
          op_count_d         = op_count + 16'd1;
        end else if (timeout_hit) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_sum_d          = QNAN;
          rsp_err_d          = 1'b1;
          fpa_reset_d        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= ID_W'(N_REQ - 1);
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_sum       <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      op_count      <= '0;
      fpa.fpa_reset <= 1'b1;
      fpa.fpa_start <= 1'b0;
      fpa.fpa_a     <= '0;
      fpa.fpa_b     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      gnt           <= gnt_d;
      rsp_valid     <= rsp_valid_d;
      rsp_sum       <= rsp_sum_d;
      rsp_err       <= rsp_err_d;
      busy          <= busy_d;
      op_count      <= op_count_d;
      fpa.fpa_reset <= fpa_reset_d;
      fpa.fpa_start <= fpa_start_d;
      fpa.fpa_a     <= fpa_a_d;
      fpa.fpa_b     <= fpa_b_d;
    end
  end

endmodule
